// File: rtl/imem_loader.sv
// imem_loader: write-side loader for the instruction memory.
//
// Accepts a byte stream over a valid/ready handshake and packs it MSB-first
// into 32-bit words. The first byte of a word lands in [31:24]. Each word is
// written to consecutive word-aligned addresses. `loading` is high while an
// image is in flight, so the top level can hold the fetch path.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   Defined: after the final word, one checksum byte is accepted. The 8-bit
//   sum of all image bytes plus the checksum must be 0, otherwise ERROR.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   start              begin a load at address 0 (sampled in IDLE/ERROR)
//   byte_valid/ready   stream handshake; byte_data, byte_last qualify it
//   mem_we/addr/wdata  instruction memory write port (one cycle per word)
//   loading            image transfer in progress
//   done               one-cycle pulse on success
//   error              sticky failure (misaligned end, overflow, checksum)
//   word_count         words written in the current or last load
//   dbg_state          current FSM state, for checkers
//
// Handshake: a byte moves on a rising edge where byte_valid && byte_ready.
// byte_ready is decoded from registered state only. It never depends
// combinationally on byte_valid. The producer holds its byte until it is taken.
module imem_loader #(
   parameter int MEM_BYTES  = 256,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   input  logic                  byte_last,
   output logic                  byte_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  loading,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH-2:0] word_count,
   output logic [2:0]            dbg_state
);

`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE, S_RECV, S_WRITE, S_CSUM, S_DONE, S_ERROR
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERROR
   } state_t;
`endif

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_BYTES - 4);
   localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(4);

   state_t                state, state_n;
   logic [ADDR_WIDTH-1:0] addr;
   logic [31:0]           word;
   logic [1:0]            idx;
   logic                  last_flag;
   logic [ADDR_WIDTH-2:0] wcount;
   logic [4:0]            lane_lo;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] sum;
   logic [7:0] csum_total;
   assign csum_total = sum + byte_data;
`endif

   // Byte idx goes to lane 3-idx, so the first byte ends up in [31:24].
   assign lane_lo = {~idx, 3'b000};

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE:  if (start) state_n = S_RECV;
         S_RECV: begin
            if (byte_valid) begin
               if (idx == 2'd3)    state_n = S_WRITE;
               else if (byte_last) state_n = S_ERROR;
            end
         end
         S_WRITE: begin
            if (last_flag) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_n = S_CSUM;
`else
               state_n = S_DONE;
`endif
            end else if (addr == LAST_ADDR) begin
               state_n = S_ERROR;
            end else begin
               state_n = S_RECV;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (byte_valid) state_n = (csum_total == 8'h00) ? S_DONE : S_ERROR;
         end
`endif
         S_DONE:  state_n = S_IDLE;
         S_ERROR: if (start) state_n = S_RECV;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr      <= '0;
         word      <= '0;
         idx       <= '0;
         last_flag <= 1'b0;
         wcount    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum       <= '0;
`endif
      end else begin
         unique case (state)
            S_IDLE, S_ERROR: begin
               if (start) begin
                  addr      <= '0;
                  idx       <= '0;
                  last_flag <= 1'b0;
                  wcount    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  sum       <= '0;
`endif
               end
            end
            S_RECV: begin
               if (byte_valid) begin
                  word[lane_lo +: 8] <= byte_data;
                  idx                <= idx + 2'd1;
                  if (idx == 2'd3) last_flag <= byte_last;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  sum <= sum + byte_data;
`endif
               end
            end
            S_WRITE: begin
               wcount <= wcount + 1'b1;
               // Hold at the top word instead of wrapping back to 0.
               if (addr != LAST_ADDR) addr <= addr + ADDR_STEP;
            end
            default: ;
         endcase
      end
   end

   assign byte_ready = (state == S_RECV)
`ifdef IMEM_LOADER_CHECKSUM_EN
                     || (state == S_CSUM)
`endif
                     ;
   assign mem_we     = (state == S_WRITE);
   assign mem_addr   = addr;
   assign mem_wdata  = word;
   assign loading    = (state == S_RECV) || (state == S_WRITE)
`ifdef IMEM_LOADER_CHECKSUM_EN
                     || (state == S_CSUM)
`endif
                     ;
   assign done       = (state == S_DONE);
   assign error      = (state == S_ERROR);
   assign word_count = wcount;
   assign dbg_state  = state;

endmodule

// File: doc/imem_loader.md
# imem_loader

Write-side counterpart of the instruction memory. It accepts a byte stream over a valid/ready handshake and packs it MSB-first into 32-bit instruction words. Each word is written to consecutive word-aligned byte addresses of the instruction memory write port. It asserts `loading` so the top level can hold `PC_enable`/`IF_ID_Enable` low and `reset` the fetch path until the program image is in place. This replaces the simulation-only `$readmemb` preload.

## Interface
- `MEM_BYTES`, 256: instruction memory size in bytes. Power of two, at least 8.
- `ADDR_WIDTH`, 8: byte address width. Must equal log2(`MEM_BYTES`).

- `clk` in 1: system clock; all logic rises on posedge.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `start` in 1: begin a load at address 0. Sampled only in IDLE or ERROR.
- `byte_valid` in 1: producer has a byte.
- `byte_data` in 8: stream byte.
- `byte_last` in 1: qualifies the final image byte. Meaningful only with `byte_valid`.
- `byte_ready` out 1: loader accepts a byte this cycle.
- `mem_we` out 1: instruction memory write strobe, one cycle per word.
- `mem_addr` out `ADDR_WIDTH`: word-aligned byte address; bits [1:0] are always 0.
- `mem_wdata` out 32: packed word. The first byte received occupies [31:24].
- `loading` out 1: high from the cycle after `start` is accepted until DONE or ERROR.
- `done` out 1: one-cycle pulse on successful completion.
- `error` out 1: sticky failure flag. Cleared by `start` or `reset`.
- `word_count` out `ADDR_WIDTH-1`: words written in the current or last load.

## Operation
- States: IDLE, RECV, WRITE, CSUM (only with the macro), DONE, ERROR.
- **IDLE**
  - On `start`: go to RECV; clear the address, byte index, word_count, error and checksum.
- **RECV**
  - `byte_ready`=1.
  - A byte is accepted when `byte_valid`&`byte_ready`. It is shifted into the word register at lane 3-idx, and idx increments.
  - Accepting byte idx 3: go to WRITE and latch `byte_last` into a last flag.
  - Accepting `byte_last` with idx≠3: go to ERROR (misaligned). No write occurs; the partial word is discarded.
- **WRITE**
  - `byte_ready`=0 and `mem_we`=1 for one cycle, with the current addr and word.
  - Then addr+=4 and word_count+=1.
  - If last: go to CSUM when the macro is defined, else DONE.
  - Else if addr was `MEM_BYTES`-4: go to ERROR (overflow). The address never wraps to 0.
  - Else: go to RECV.
- **DONE**
  - `done`=1 for one cycle, then IDLE. `word_count` holds.
- **ERROR**
  - `error`=1 and `loading`=0. Stays in ERROR until `start` (restart) or `reset`.
- `start` in RECV, WRITE or CSUM is ignored.
- Bytes presented while `byte_ready`=0 are not consumed.

## Timing
- Reset values: `byte_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `loading`=0, `done`=0, `error`=0, `word_count`=0; state IDLE.
- All outputs are registered or decoded from registered state. There is no combinational path from `byte_valid` to `byte_ready`.
- `start` at cycle N: `loading`=1 and `byte_ready`=1 at N+1.
- The 4th byte of a word is accepted at cycle M: `mem_we` is high at M+1.
- Peak throughput is 4 bytes per 5 cycles.
- Final write at cycle W (no macro): `done`=1 and `loading`=0 at W+1.
- `reset` mid-operation: immediate return to IDLE with reset values. No partial word is written.

## Configuration
- Macro: `IMEM_LOADER_CHECKSUM_EN`.
- **Defined:**
  - An 8-bit modular sum of every accepted byte is kept.
  - After the final WRITE, the loader enters CSUM with `byte_ready`=1 and accepts exactly one checksum byte; `byte_last` is ignored there.
  - If (sum + checksum) mod 256 == 0: DONE on the next cycle. Otherwise ERROR.
  - `loading` stays high through CSUM.
- **Undefined:**
  - No CSUM state or sum register exists. Completion follows the final WRITE directly.

## Test plan
- **Basic load:** `start`, then bytes E2 11 00 00 E0 80 51 83 with `byte_last` on the 8th byte.
  - `mem_we` at addr 0 with E2110000, then at addr 4 with E0805183.
  - `done` pulses once; `word_count`=2; `loading` falls with `done`.
- **Backpressure and gaps:** same stream with `byte_valid` toggling 1/0 every cycle.
  - Identical writes and data; exactly 2 `mem_we` pulses; no byte duplicated or dropped.
- **Misaligned end:** bytes 1A FF FF with `byte_last` on the 3rd byte.
  - `error`=1 next cycle; no `mem_we`; `loading`=0.
  - A following `start` clears `error`.
- **Overflow:** `MEM_BYTES`=8, 12 bytes without `byte_last`.
  - Writes at addr 0 and 4; `error`=1 after the second write; no third write.
- **Reset mid-word:** `start`, bytes DB 00, then `reset` for one cycle.
  - All outputs at reset values.
  - A new `start` plus bytes 00 00 00 00 (last) writes 00000000 at addr 0.
- **Checksum (macro defined):** word E2 11 00 00 (last), then checksum 0D.
  - `done`=1.
  - Repeating with checksum 0E gives `error`=1 after the addr 0 write.
